// File: rtl/bj_pkg.sv
// Shared definitions for the blackjack result receiver.
//   PW     probability word width (serial burst length)
//   PMAX   largest legal probability value (percent)
//   NPROB  probability words expected per game before the winner burst
//   win_t  winner codes; state_t receiver FSM encoding
//   sat_inc16  saturating 16-bit increment for the optional statistics
package bj_pkg;

    localparam int unsigned      PW    = 7;
    localparam logic [PW-1:0]    PMAX  = PW'(100);
    localparam logic [2:0]       NPROB = 3'd4;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } win_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROB  = 2'd1,
        ST_WIN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bj_result_rx_if.sv
// Serial result link plus decoded results of the blackjack receiver.
//   master: drives the serial link (rx_*), observes the decoded results
//   slave : the receiver; consumes rx_*, drives eq_prob/ex_prob/prob_valid/
//           prob_idx/win_code/win_valid/len_err/range_err/seq_err
// BJ_RX_STATS_EN adds games/wins1/wins2/ties counters to the slave side.
interface bj_result_rx_if;
    import bj_pkg::*;

    logic          rx_valid1;
    logic          rx_equal;
    logic          rx_exceed;
    logic          rx_valid2;
    logic          rx_winner;

    logic [PW-1:0] eq_prob;
    logic [PW-1:0] ex_prob;
    logic          prob_valid;
    logic [1:0]    prob_idx;
    logic [1:0]    win_code;
    logic          win_valid;
    logic          len_err;
    logic          range_err;
    logic          seq_err;

`ifdef BJ_RX_STATS_EN
    logic [15:0]   games;
    logic [15:0]   wins1;
    logic [15:0]   wins2;
    logic [15:0]   ties;

    modport master (
        output rx_valid1, rx_equal, rx_exceed, rx_valid2, rx_winner,
        input  eq_prob, ex_prob, prob_valid, prob_idx, win_code, win_valid,
               len_err, range_err, seq_err, games, wins1, wins2, ties
    );
    modport slave (
        input  rx_valid1, rx_equal, rx_exceed, rx_valid2, rx_winner,
        output eq_prob, ex_prob, prob_valid, prob_idx, win_code, win_valid,
               len_err, range_err, seq_err, games, wins1, wins2, ties
    );
`else
    modport master (
        output rx_valid1, rx_equal, rx_exceed, rx_valid2, rx_winner,
        input  eq_prob, ex_prob, prob_valid, prob_idx, win_code, win_valid,
               len_err, range_err, seq_err
    );
    modport slave (
        input  rx_valid1, rx_equal, rx_exceed, rx_valid2, rx_winner,
        output eq_prob, ex_prob, prob_valid, prob_idx, win_code, win_valid,
               len_err, range_err, seq_err
    );
`endif

endinterface

// File: rtl/bj_ser_shift.sv
// PW-bit MSB-first serial-to-parallel shift register with burst bit counter.
//   clk, rst : clock, synchronous active-high reset
//   start    : first bit of a burst (counter restarts at 1)
//   shift    : further bit of the same burst
//   din      : serial bit
//   data     : last PW bits shifted in, MSB first
//   len_ok   : exactly PW bits seen since start
module bj_ser_shift
    import bj_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          shift,
    input  logic          din,
    output logic [PW-1:0] data,
    output logic          len_ok
);

    localparam int unsigned    CW      = $clog2(PW + 2);
    // Saturating at PW+1 keeps over-long bursts distinguishable from legal ones.
    localparam logic [CW-1:0]  CNT_MAX = CW'(PW + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (start) begin
            data <= {data[PW-2:0], din};
            cnt  <= CW'(1);
        end else if (shift) begin
            data <= {data[PW-2:0], din};
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end
    end

    assign len_ok = (cnt == CW'(PW));

endmodule

// File: rtl/bj_result_rx.sv
// Blackjack result receiver: deserialises the equal/exceed probability bursts
// and the winner burst, checking burst length, value range and game sequence.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : bj_result_rx_if.slave (serial inputs, decoded pulse outputs)
// Optional feature macro: BJ_RX_STATS_EN (games/wins1/wins2/ties counters).
module bj_result_rx
    import bj_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    bj_result_rx_if.slave  bus
);

    localparam int NUM_LANES = 2;   // lane 0 = equal, lane 1 = exceed

    logic [NUM_LANES-1:0]         lane_bit;
    logic [NUM_LANES-1:0]         lane_ok;
    logic [NUM_LANES-1:0][PW-1:0] lane_data;

    state_t        state;
    logic [2:0]    word_cnt;     // 0..NPROB, one bit wider than prob_idx
    logic          win_two;      // second winner bit captured
    logic          win_b0;
    logic          win_b1;
    logic          both;
    logic          sh_start;
    logic          sh_shift;
    logic          len_ok;

    logic [PW-1:0] eq_prob;
    logic [PW-1:0] ex_prob;
    logic          prob_valid;
    logic [1:0]    prob_idx;
    logic [1:0]    win_code;
    logic          win_valid;
    logic          len_err;
    logic          range_err;
    logic          seq_err;

    assign both     = bus.rx_valid1 & bus.rx_valid2;
    assign sh_start = (state == ST_IDLE) & bus.rx_valid1 & ~bus.rx_valid2;
    assign sh_shift = (state == ST_PROB) & bus.rx_valid1 & ~bus.rx_valid2;
    assign lane_bit = {bus.rx_exceed, bus.rx_equal};
    assign len_ok   = &lane_ok;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        bj_ser_shift u_shift (
            .clk    (clk),
            .rst    (rst),
            .start  (sh_start),
            .shift  (sh_shift),
            .din    (lane_bit[l]),
            .data   (lane_data[l]),
            .len_ok (lane_ok[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            win_two    <= 1'b0;
            win_b0     <= 1'b0;
            win_b1     <= 1'b0;
            eq_prob    <= '0;
            ex_prob    <= '0;
            prob_valid <= 1'b0;
            prob_idx   <= '0;
            win_code   <= WIN_NONE;
            win_valid  <= 1'b0;
            len_err    <= 1'b0;
            range_err  <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prob_valid <= 1'b0;
            win_valid  <= 1'b0;
            len_err    <= 1'b0;
            range_err  <= 1'b0;
            seq_err    <= 1'b0;

            if (both) begin
                // Both valids together is a protocol violation in any state:
                // drop whatever burst was in flight and resync on a quiet link.
                seq_err <= 1'b1;
                state   <= ST_FLUSH;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_valid1) begin
                            state <= ST_PROB;
                        end else if (bus.rx_valid2) begin
                            win_b0  <= bus.rx_winner;
                            win_two <= 1'b0;
                            state   <= ST_WIN;
                        end
                    end

                    ST_PROB: begin
                        if (!bus.rx_valid1) begin
                            state <= ST_IDLE;
                            if (len_ok) begin
                                eq_prob    <= lane_data[0];
                                ex_prob    <= lane_data[1];
                                prob_valid <= 1'b1;
                                range_err  <= (lane_data[0] > PMAX) || (lane_data[1] > PMAX);
                                if (word_cnt >= NPROB) begin
                                    // Extra word without a winner: restart the game count.
                                    prob_idx <= 2'd0;
                                    seq_err  <= 1'b1;
                                    word_cnt <= 3'd1;
                                end else begin
                                    prob_idx <= word_cnt[1:0];
                                    word_cnt <= word_cnt + 3'd1;
                                end
                            end else begin
                                len_err <= 1'b1;
                            end
                        end
                    end

                    ST_WIN: begin
                        if (bus.rx_valid2) begin
                            if (!win_two) begin
                                win_b1  <= bus.rx_winner;
                                win_two <= 1'b1;
                            end else begin
                                len_err  <= 1'b1;
                                word_cnt <= '0;
                                state    <= ST_FLUSH;
                            end
                        end else begin
                            state    <= ST_IDLE;
                            word_cnt <= '0;
                            seq_err  <= (word_cnt != NPROB);
                            if (!win_two && !win_b0) begin
                                win_code  <= WIN_NONE;
                                win_valid <= 1'b1;
                            end else if (win_two && win_b0 && !win_b1) begin
                                win_code  <= WIN_P1;
                                win_valid <= 1'b1;
                            end else if (win_two && win_b0 && win_b1) begin
                                win_code  <= WIN_P2;
                                win_valid <= 1'b1;
                            end else begin
                                len_err <= 1'b1;
                            end
                        end
                    end

                    default: begin  // ST_FLUSH
                        if (!bus.rx_valid1 && !bus.rx_valid2) state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.eq_prob    = eq_prob;
    assign bus.ex_prob    = ex_prob;
    assign bus.prob_valid = prob_valid;
    assign bus.prob_idx   = prob_idx;
    assign bus.win_code   = win_code;
    assign bus.win_valid  = win_valid;
    assign bus.len_err    = len_err;
    assign bus.range_err  = range_err;
    assign bus.seq_err    = seq_err;

`ifdef BJ_RX_STATS_EN
    logic [15:0] games;
    logic [15:0] wins1;
    logic [15:0] wins2;
    logic [15:0] ties;

    // Counts follow the registered win_valid pulse, so they settle one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            games <= '0;
            wins1 <= '0;
            wins2 <= '0;
            ties  <= '0;
        end else if (win_valid) begin
            games <= sat_inc16(games);
            case (win_code)
                WIN_P1:  wins1 <= sat_inc16(wins1);
                WIN_P2:  wins2 <= sat_inc16(wins2);
                default: ties  <= sat_inc16(ties);
            endcase
        end
    end

    assign bus.games = games;
    assign bus.wins1 = wins1;
    assign bus.wins2 = wins2;
    assign bus.ties  = ties;
`endif

endmodule

// File: tb/tb_bj_result_rx.sv
module tb_bj_result_rx;
    import bj_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bj_result_rx_if bus();

    bj_result_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       pv, wv, le, re, se;
        logic [6:0] eq, ex;
        logic [1:0] idx, code;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [6:0] m_eq  = '0;
    logic [6:0] m_ex  = '0;
    logic [1:0] m_code = '0;
    int         m_wc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_valid1 = 1'b0;
        bus.rx_valid2 = 1'b0;
        bus.rx_equal  = 1'b0;
        bus.rx_exceed = 1'b0;
        bus.rx_winner = 1'b0;
        repeat (n) tick();
    endtask

    // n-bit probability burst (MSB first) followed by the one idle cycle that ends it.
    task automatic send_prob(input logic [7:0] eq, input logic [7:0] ex, input int n);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            bus.rx_valid1 = 1'b1;
            bus.rx_equal  = eq[i];
            bus.rx_exceed = ex[i];
            tick();
        end
        e = '{default: '0};
        if (n == 7) begin
            m_eq = eq[6:0];
            m_ex = ex[6:0];
            e.pv = 1'b1;
            e.re = (eq[6:0] > 7'd100) || (ex[6:0] > 7'd100);
            if (m_wc >= 4) begin
                e.idx = 2'd0;
                e.se  = 1'b1;
                m_wc  = 1;
            end else begin
                e.idx = m_wc[1:0];
                m_wc++;
            end
        end else begin
            e.le = 1'b1;
        end
        e.eq   = m_eq;
        e.ex   = m_ex;
        e.code = m_code;
        sbq.push_back(e);
        idle(1);
    endtask

    task automatic send_win(input int n, input logic b0, input logic b1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.rx_valid2 = 1'b1;
            bus.rx_winner = (i == 0) ? b0 : b1;
            tick();
        end
        e = '{default: '0};
        if (n == 1 && !b0) begin
            m_code = 2'b00; e.wv = 1'b1;
        end else if (n == 2 && b0 && !b1) begin
            m_code = 2'b01; e.wv = 1'b1;
        end else if (n == 2 && b0 && b1) begin
            m_code = 2'b10; e.wv = 1'b1;
        end else begin
            e.le = 1'b1;
        end
        e.se   = (m_wc != 4);
        m_wc   = 0;
        e.eq   = m_eq;
        e.ex   = m_ex;
        e.code = m_code;
        sbq.push_back(e);
        idle(1);
    endtask

    task automatic words(input int n);
        for (int i = 0; i < n; i++)
            send_prob(8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)), 7);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_eq"},  32'(bus.eq_prob), 0);
        chk({tag, "_ex"},  32'(bus.ex_prob), 0);
        chk({tag, "_idx"}, 32'(bus.prob_idx), 0);
        chk({tag, "_code"}, 32'(bus.win_code), 0);
        chk({tag, "_pulses"}, 32'({bus.prob_valid, bus.win_valid, bus.len_err,
                                   bus.range_err, bus.seq_err}), 0);
    endtask

    // Scoreboard monitor: every cycle carrying a pulse consumes one expectation.
    logic [4:0] mon_pulses;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            mon_pulses = {bus.prob_valid, bus.win_valid, bus.len_err, bus.range_err, bus.seq_err};
            if (mon_pulses != 5'b0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'(mon_pulses), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("prob_valid", 32'(bus.prob_valid), 32'(mon_e.pv));
                    chk("win_valid",  32'(bus.win_valid),  32'(mon_e.wv));
                    chk("len_err",    32'(bus.len_err),    32'(mon_e.le));
                    chk("range_err",  32'(bus.range_err),  32'(mon_e.re));
                    chk("seq_err",    32'(bus.seq_err),    32'(mon_e.se));
                    chk("eq_prob",    32'(bus.eq_prob),    32'(mon_e.eq));
                    chk("ex_prob",    32'(bus.ex_prob),    32'(mon_e.ex));
                    chk("win_code",   32'(bus.win_code),   32'(mon_e.code));
                    if (mon_e.pv) chk("prob_idx", 32'(bus.prob_idx), 32'(mon_e.idx));
                end
            end
        end
    end

    initial begin
        exp_t e;
        idle(3);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Reference word (80/25), then a full legal game won by player 1.
        send_prob(8'b0101_0000, 8'b0001_1001, 7);
        send_prob(8'd10, 8'd20, 7);
        send_prob(8'd30, 8'd40, 7);
        send_prob(8'd100, 8'd0, 7);          // PMAX itself is legal
        send_win(2, 1'b1, 1'b0);

        words(4); send_win(1, 1'b0, 1'b0);   // tie
        words(4); send_win(2, 1'b1, 1'b1);   // player 2
        words(4); send_win(1, 1'b1, 1'b0);   // single '1' is illegal

        // Wrong lengths leave the words untouched.
        send_prob(8'd55, 8'd66, 6);
        send_prob(8'd55, 8'd66, 8);

        // Out-of-range word still delivered; early winner flags sequence.
        send_prob(8'd127, 8'd5, 7);
        send_prob(8'd101, 8'd99, 7);
        send_win(2, 1'b1, 1'b0);

        // Fifth word wraps the index.
        words(5);
        send_win(2, 1'b1, 1'b1);

        // Both valids mid-burst: abort, flush until the link goes quiet.
        words(1);
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid1 = 1'b1; bus.rx_equal = 1'b1; bus.rx_exceed = 1'b0; tick();
        end
        bus.rx_valid2 = 1'b1;
        e = '{default: '0};
        e.se = 1'b1; e.eq = m_eq; e.ex = m_ex; e.code = m_code;
        sbq.push_back(e);
        tick();
        bus.rx_valid2 = 1'b0;
        repeat (2) tick();                  // rx_valid1 alone: still flushing, silent
        idle(1);
        send_prob(8'd42, 8'd17, 7);         // resumes at the pre-abort word count
        words(2);
        send_win(2, 1'b1, 1'b0);

        // Reset in the middle of a burst.
        idle(2);
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid1 = 1'b1; bus.rx_equal = 1'b1; bus.rx_exceed = 1'b1; tick();
        end
        rst = 1'b1;
        idle(1);
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        m_eq = '0; m_ex = '0; m_code = '0; m_wc = 0;
        idle(1);
        send_prob(8'b0101_0000, 8'b0001_1001, 7);
        words(3);
        send_win(2, 1'b1, 1'b1);

        idle(4);
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
